fp_to_int_converter: RTL and testbench

Sequential IEEE-754 single-precision to signed 32-bit integer converter. It is the decoding counterpart of the FP arithmetic units: it consumes a packed float (for example, a result from the adder/subtractor), unpacks sign, exponent and fraction, and shifts the mantissa one bit per cycle to produce a two's-complement integer. Rounding is toward zero. The block sits between the FP datapath and integer consumers, with valid/ready handshakes on both sides.

---
 rtl/fp_to_int_converter.sv | 185 ++++++++++++++++++
 tb/tb_fp_to_int_converter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_converter.sv
//------------------------------------------------------------------------------
// Module      : fp_to_int_converter
// Description : IEEE-754 single to signed 32-bit integer, round toward zero,
//               one mantissa shift per cycle, valid/ready on both sides.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_to_int_converter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        invalid,
  output logic        inexact
);

  localparam logic [7:0]  C_EXP_BIAS   = 8'd127;
  localparam logic [7:0]  C_EXP_UNITY  = 8'd150;  // e = 23: mantissa already integer-aligned
  localparam logic [7:0]  C_EXP_SAT    = 8'd158;  // e = 31
  localparam logic [31:0] C_INT_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] C_INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        inv_q, inv_d;
  logic        inx_q, inx_d;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic        w_frac_nz;
  logic        w_shift_left;
  logic [4:0]  w_shift_cnt;
  logic [31:0] w_sat;

  assign w_sign       = a[31];
  assign w_exp        = a[30:23];
  assign w_frac       = a[22:0];
  assign w_frac_nz    = |w_frac;
  assign w_shift_left = (w_exp >= C_EXP_UNITY);
  assign w_sat        = w_sign ? C_INT_MIN : C_INT_MAX;

  // |E - 150| is below 32 on the normal path, so 5-bit modular arithmetic
  // on the low exponent bits gives the exact count (150 mod 32 = 22).
  assign w_shift_cnt  = w_shift_left ? (w_exp[4:0] - 5'd22) : (5'd22 - w_exp[4:0]);

  assign in_ready     = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;
  assign overflow     = ovf_q;
  assign invalid      = inv_q;
  assign inexact      = inx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mag_q    <= 32'd0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      inx_q    <= inx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sign_d   = sign_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    inx_d    = inx_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = w_sign;
          mag_d    = {8'b0, 1'b1, w_frac};
          left_d   = w_shift_left;
          cnt_d    = w_shift_cnt;
          result_d = 32'd0;
          ovf_d    = 1'b0;
          inv_d    = 1'b0;
          inx_d    = 1'b0;
          if (w_exp == 8'hFF) begin
            state_d = S_DONE;
            if (w_frac_nz) begin
              inv_d = 1'b1;
            end else begin
              result_d = w_sat;
              ovf_d    = 1'b1;
            end
          end else if (w_exp == 8'd0) begin
            state_d = S_DONE;
            inx_d   = w_frac_nz;
          end else if (w_exp < C_EXP_BIAS) begin
            state_d = S_DONE;
            inx_d   = 1'b1;
          end else if (w_exp >= C_EXP_SAT) begin
            state_d = S_DONE;
            // -2^31 is the only magnitude at e >= 31 that still fits
            if (w_exp == C_EXP_SAT && w_sign && !w_frac_nz) begin
              result_d = C_INT_MIN;
            end else begin
              result_d = w_sat;
              ovf_d    = 1'b1;
            end
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (cnt_q == 5'd0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (left_q) begin
            mag_d = mag_q << 1;
          end else begin
            mag_d = mag_q >> 1;
            if (mag_q[0]) begin
              inx_d = 1'b1;
            end
          end
          if (cnt_q == 5'd1) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        result_d = sign_q ? (~mag_q + 32'd1) : mag_q;
        state_d  = S_DONE;
      end

      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_to_int_converter.sv
// Scoreboard bench for fp_to_int_converter: directed vectors, decoupled
// driver and monitor, plus backpressure and mid-operation reset scenarios.
`timescale 1ns/1ps
`default_nettype none

module tb_fp_to_int_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        result_ready = 1'b1;
  logic [31:0] a = 32'd0;
  logic        in_ready;
  logic        result_valid;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;
  logic        inexact;

  fp_to_int_converter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .overflow     (overflow),
    .invalid      (invalid),
    .inexact      (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] r;
    logic [2:0]  flags;   // {overflow, invalid, inexact}
    int          lat;     // 0 = latency not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   n_acc   = 0;
  int   first_lat = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Monitor: tracks accepts and first-valid cycle, checks on each result handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc + 1;
        n_acc++;
      end
      if (result_valid && !seen) begin
        seen      = 1'b1;
        first_lat = cyc - acc_cyc + 1;
      end
      if (result_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected result", 1'b0, result, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("result a=%08h", mon_e.a), result === mon_e.r, result, mon_e.r);
          chk($sformatf("flags{ovf,inv,inx} a=%08h", mon_e.a),
              {overflow, invalid, inexact} === mon_e.flags,
              {29'd0, overflow, invalid, inexact}, {29'd0, mon_e.flags});
          if (mon_e.lat > 0)
            chk($sformatf("latency a=%08h", mon_e.a), first_lat == mon_e.lat,
                32'(first_lat), 32'(mon_e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at the posedge+1 following the accept edge
  task automatic send(input logic [31:0] v, input logic [31:0] r, input logic [2:0] fl,
                      input int lat, input bit push);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready wait timeout", 1'b0, 32'(in_ready), 32'd1);
    a        = v;
    in_valid = 1'b1;
    if (push) begin
      e.a = v; e.r = r; e.flags = fl; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || !in_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb_q.size() != 0) chk("drain timeout", 1'b0, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result",       result == 32'd0, result, 32'd0);
    chk("reset result_valid", result_valid == 1'b0, 32'(result_valid), 32'd0);
    chk("reset flags",        {overflow, invalid, inexact} == 3'b000,
        {29'd0, overflow, invalid, inexact}, 32'd0);
    chk("reset in_ready",     in_ready == 1'b1, 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h3FC0_0000, 32'h0000_0001, 3'b001, 25, 1'b1);
    send(32'hC2F6_0000, 32'hFFFF_FF85, 3'b000, 19, 1'b1);
    send(32'h4F00_0000, 32'h7FFF_FFFF, 3'b100,  1, 1'b1);
    send(32'hCF00_0000, 32'h8000_0000, 3'b000,  1, 1'b1);
    send(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000,  9, 1'b1);
    send(32'h7FC0_0000, 32'h0000_0000, 3'b010,  1, 1'b1);
    send(32'hFF80_0000, 32'h8000_0000, 3'b100,  1, 1'b1);
    send(32'h0000_0001, 32'h0000_0000, 3'b001,  1, 1'b1);
    send(32'h8000_0000, 32'h0000_0000, 3'b000,  1, 1'b1);
    send(32'h3F00_0000, 32'h0000_0000, 3'b001,  1, 1'b1);
    send(32'hC000_0000, 32'hFFFF_FFFE, 3'b000, 24, 1'b1);
    send(32'h4B80_0001, 32'h0100_0002, 3'b000,  3, 1'b1);
    send(32'h7F80_0000, 32'h7FFF_FFFF, 3'b100,  1, 1'b1);
    send(32'h4B00_0000, 32'h0080_0000, 3'b000,  0, 1'b1);
    send(32'hFF80_0001, 32'h0000_0000, 3'b010,  1, 1'b1);
    send(32'hCF00_0001, 32'h8000_0000, 3'b100,  1, 1'b1);
    send(32'h3FFF_FFFF, 32'h0000_0001, 3'b001, 25, 1'b1);
    drain();

    // Backpressure: result held, no second accept while in_valid pulses
    result_ready = 1'b0;
    send(32'h4120_0000, 32'h0000_000A, 3'b000, 22, 1'b1);
    t = 0;
    while (!result_valid && t < 60) begin
      a        = 32'h3F80_0000;
      in_valid = ~in_valid;
      @(posedge clk); #1;
      t++;
    end
    chk("backpressure result_valid", result_valid == 1'b1, 32'(result_valid), 32'd1);
    n0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      chk("held result",   result == 32'h0000_000A, result, 32'h0000_000A);
      chk("held valid",    result_valid == 1'b1, 32'(result_valid), 32'd1);
      chk("busy in_ready", in_ready == 1'b0, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("no second accept", n_acc == n0, 32'(n_acc), 32'(n0));
    in_valid     = 1'b0;
    result_ready = 1'b1;
    chk("in_ready on handshake cycle", in_ready == 1'b0, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready after handshake", in_ready == 1'b1, 32'(in_ready), 32'd1);
    drain();

    // Reset in the middle of a long right shift
    send(32'h3FC0_0000, 32'h0, 3'b000, 0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset result",       result == 32'd0, result, 32'd0);
    chk("midreset result_valid", result_valid == 1'b0, 32'(result_valid), 32'd0);
    chk("midreset flags",        {overflow, invalid, inexact} == 3'b000,
        {29'd0, overflow, invalid, inexact}, 32'd0);
    chk("midreset in_ready",     in_ready == 1'b1, 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h42F6_0000, 32'h0000_007B, 3'b000, 19, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
